alu_issue_decode: RTL and testbench

Front end of the ALU interface. Decodes RV32I instruction words into the 4-bit ALU ctrl code, operand selects, immediate and register indices. Sits between fetch and execute, so execute drives the ALU directly from this block's outputs. Registered output with valid/ready handshake, a 2-entry skid buffer so in_ready is a flop, and a flush input.

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_issue_decode_if.sv | 35 +++
 rtl/alu_issue_dec_comb.sv | 106 ++++++++++
 rtl/alu_issue_decode.sv | 76 +++++++
 tb/tb_alu_issue_decode.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ctrl codes, RV32I opcodes, operand selects and the
// decoded-entry bundle passed from issue decode to execute.
package alu_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SUB     = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_EQ      = 4'd5;
  localparam logic [3:0] ALU_NE      = 4'd6;
  localparam logic [3:0] ALU_LTU     = 4'd7;
  localparam logic [3:0] ALU_GEU     = 4'd8;
  localparam logic [3:0] ALU_LT      = 4'd9;
  localparam logic [3:0] ALU_GE      = 4'd10;
  localparam logic [3:0] ALU_SLL     = 4'd11;
  localparam logic [3:0] ALU_SRL     = 4'd12;
  localparam logic [3:0] ALU_SRA     = 4'd13;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] SEL_A_RS1  = 2'd0;
  localparam logic [1:0] SEL_A_PC   = 2'd1;
  localparam logic [1:0] SEL_A_ZERO = 2'd2;
  localparam logic       SEL_B_RS2  = 1'b0;
  localparam logic       SEL_B_IMM  = 1'b1;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [1:0]      sel_a;
    logic            sel_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic            is_branch;
    logic            illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // funct3 -> ctrl for the base (funct7=0) register/immediate ALU ops
  function automatic logic [3:0] op_ctrl(input logic [2:0] f3);
    logic [3:0] c;
    case (f3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_LT;
      3'b011:  c = ALU_LTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/alu_issue_decode_if.sv
// Fetch-side and execute-side handshake bundle of the ALU issue decoder.
interface alu_issue_decode_if;
  import alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_ctrl;
  logic [1:0]      out_sel_a;
  logic            out_sel_b;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_is_branch;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_sel_a, out_sel_b, out_imm,
           out_pc, out_rs1, out_rs2, out_rd, out_rd_we, out_is_branch, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_sel_a, out_sel_b, out_imm,
           out_pc, out_rs1, out_rs2, out_rd, out_rd_we, out_is_branch, out_illegal
  );
endinterface

// File: rtl/alu_issue_dec_comb.sv
// Combinational RV32I decode of one instruction word into the ALU entry bundle.
module alu_issue_dec_comb
  import alu_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_CTRL = ALU_ILLEGAL
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output dec_t            dec
);
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic        bad, writes, branch;
  logic [3:0]  ctrl;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt  = {27'b0, inst[24:20]};

  always_comb begin
    dec       = '0;
    dec.pc    = pc;
    dec.rs1   = inst[19:15];
    dec.rs2   = inst[24:20];
    dec.rd    = inst[11:7];
    dec.sel_a = SEL_A_RS1;
    dec.sel_b = SEL_B_RS2;
    ctrl      = ALU_ADD;
    bad       = 1'b0;
    writes    = 1'b0;
    branch    = 1'b0;
    case (opcode)
      OPC_OP: begin
        writes = 1'b1;
        if (f7 == 7'b0000000)                       ctrl = op_ctrl(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)  ctrl = ALU_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)  ctrl = ALU_SRA;
        else                                        bad  = 1'b1;
      end
      OPC_OP_IMM: begin
        writes    = 1'b1;
        dec.sel_b = SEL_B_IMM;
        if (f3 == 3'b001) begin
          dec.imm = shamt;
          ctrl    = ALU_SLL;
          bad     = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec.imm = shamt;
          if (f7 == 7'b0000000)      ctrl = ALU_SRL;
          else if (f7 == 7'b0100000) ctrl = ALU_SRA;
          else                       bad  = 1'b1;
        end else begin
          dec.imm = imm_i;
          ctrl    = op_ctrl(f3);
        end
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        branch  = 1'b1;
        case (f3)
          3'b000:  ctrl = ALU_EQ;
          3'b001:  ctrl = ALU_NE;
          3'b100:  ctrl = ALU_LT;
          3'b101:  ctrl = ALU_GE;
          3'b110:  ctrl = ALU_LTU;
          3'b111:  ctrl = ALU_GEU;
          default: bad  = 1'b1;
        endcase
      end
      OPC_LOAD:  begin writes = 1'b1; dec.sel_b = SEL_B_IMM; dec.imm = imm_i; end
      OPC_STORE: begin dec.sel_b = SEL_B_IMM; dec.imm = imm_s; end
      OPC_LUI: begin
        writes = 1'b1; dec.sel_a = SEL_A_ZERO; dec.sel_b = SEL_B_IMM; dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        writes = 1'b1; dec.sel_a = SEL_A_PC; dec.sel_b = SEL_B_IMM; dec.imm = imm_u;
      end
      OPC_JAL: begin
        writes = 1'b1; dec.sel_a = SEL_A_PC; dec.sel_b = SEL_B_IMM; dec.imm = imm_j;
      end
      OPC_JALR: begin
        writes = 1'b1; dec.sel_b = SEL_B_IMM; dec.imm = imm_i;
        bad    = (f3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    // Illegal entries keep their operand fields but must not write or branch
    if (bad) begin
      ctrl   = ILLEGAL_CTRL;
      writes = 1'b0;
      branch = 1'b0;
    end
    dec.ctrl      = ctrl;
    dec.rd_we     = writes && (inst[11:7] != 5'd0);
    dec.is_branch = branch;
    dec.illegal   = bad;
  end
endmodule

// File: rtl/alu_issue_decode.sv
// ALU issue decoder: decode stage with registered output, 2-entry skid buffer
// (in_ready is the inverted skid valid flop) and flush.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_CTRL = ALU_ILLEGAL
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_decode_if.slave  bus
);
  dec_t dec, main_q, skid_q, main_d, skid_d;
  logic main_valid, skid_valid, main_valid_d, skid_valid_d;
  logic accept, drain;

  alu_issue_dec_comb #(.ILLEGAL_CTRL(ILLEGAL_CTRL)) u_dec (
    .inst (bus.in_inst),
    .pc   (bus.in_pc),
    .dec  (dec)
  );

  assign accept = bus.in_valid && !skid_valid;
  assign drain  = bus.out_ready || !main_valid;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.out_ctrl      = main_q.ctrl;
  assign bus.out_sel_a     = main_q.sel_a;
  assign bus.out_sel_b     = main_q.sel_b;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_pc        = main_q.pc;
  assign bus.out_rs1       = main_q.rs1;
  assign bus.out_rs2       = main_q.rs2;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_rd_we     = main_q.rd_we;
  assign bus.out_is_branch = main_q.is_branch;
  assign bus.out_illegal   = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_decode.sv
// Bench for alu_issue_decode: FIFO-of-depth-2 reference model with per-cycle
// compare, plus hand-computed expectations for key instructions.
module tb_alu_issue_decode;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_issue_decode_if bus ();

  alu_issue_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ctrl, sel_a, sel_b, imm, pc, rs1, rs2, rd, rd_we, is_branch, illegal;
  } exp_t;

  exp_t q[$];
  exp_t h;
  exp_t pin;
  bit   m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input int bits, input logic [31:0] v);
    logic [31:0] r;
    r = v << (32 - bits);
    return 32'($signed(r) >>> (32 - bits));
  endfunction

  // Decode model: reads the instruction-set rules directly, field by field.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   ops [8] = '{2, 11, 9, 7, 4, 12, 1, 0};
    int   brs [8] = '{5, 6, -1, -1, 9, 10, 7, 8};
    int   f3  = int'(w[14:12]);
    int   f7  = int'(w[31:25]);
    int   opc = int'(w[6:0]);
    int   c   = 2;
    bit   legal = 1'b1;
    bit   wr = 1'b0;
    bit   br = 1'b0;
    e.sel_a = 0; e.sel_b = 0; e.imm = 0; e.pc = pc;
    e.rs1 = 32'(w[19:15]); e.rs2 = 32'(w[24:20]); e.rd = 32'(w[11:7]);
    case (opc)
      'h33: begin
        wr = 1;
        if (f7 == 0) c = ops[f3];
        else if (f7 == 'h20 && f3 == 0) c = 3;
        else if (f7 == 'h20 && f3 == 5) c = 13;
        else legal = 0;
      end
      'h13: begin
        wr = 1; e.sel_b = 1;
        if (f3 == 1 || f3 == 5) begin
          e.imm = 32'(w[24:20]);
          if (f3 == 1) begin c = 11; legal = (f7 == 0); end
          else if (f7 == 0) c = 12;
          else if (f7 == 'h20) c = 13;
          else legal = 0;
        end else begin
          e.imm = sx(12, 32'(w[31:20]));
          c = ops[f3];
        end
      end
      'h63: begin
        e.imm = sx(13, 32'({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        c = brs[f3]; legal = (c >= 0); br = 1;
      end
      'h03: begin wr = 1; e.sel_b = 1; e.imm = sx(12, 32'(w[31:20])); end
      'h23: begin e.sel_b = 1; e.imm = sx(12, 32'({w[31:25], w[11:7]})); end
      'h37: begin wr = 1; e.sel_a = 2; e.sel_b = 1; e.imm = w & 32'hFFFFF000; end
      'h17: begin wr = 1; e.sel_a = 1; e.sel_b = 1; e.imm = w & 32'hFFFFF000; end
      'h6F: begin
        wr = 1; e.sel_a = 1; e.sel_b = 1;
        e.imm = sx(21, 32'({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      end
      'h67: begin wr = 1; e.sel_b = 1; e.imm = sx(12, 32'(w[31:20])); legal = (f3 == 0); end
      default: legal = 0;
    endcase
    if (!legal) begin c = 15; wr = 0; br = 0; end
    e.ctrl      = 32'(c);
    e.rd_we     = 32'(wr && (w[11:7] != 0));
    e.is_branch = 32'(br);
    e.illegal   = 32'(!legal);
    return e;
  endfunction

  // Reference queue: holds at most two entries, head is what execute sees.
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      m_acc = bus.in_valid && (q.size() < 2);
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (m_acc) q.push_back(model(bus.in_inst, bus.in_pc));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
        h = q[0];
        chk("ctrl", 32'(bus.out_ctrl), h.ctrl);
        chk("sel_a", 32'(bus.out_sel_a), h.sel_a);
        chk("sel_b", 32'(bus.out_sel_b), h.sel_b);
        chk("imm", bus.out_imm, h.imm);
        chk("pc", bus.out_pc, h.pc);
        chk("rs1", 32'(bus.out_rs1), h.rs1);
        chk("rs2", 32'(bus.out_rs2), h.rs2);
        chk("rd", 32'(bus.out_rd), h.rd);
        chk("rd_we", 32'(bus.out_rd_we), h.rd_we);
        chk("is_branch", 32'(bus.out_is_branch), h.is_branch);
        chk("illegal", 32'(bus.out_illegal), h.illegal);
      end
    end
  end

  // Offer one instruction until accepted; called just after a rising edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst  = i;
    bus.in_pc    = p;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  logic [31:0] tbl [14] = '{
    32'h403100B3, 32'h123452B7, 32'h00001317, 32'h010000EF, 32'h000100E7,
    32'h000110E7, 32'hFFC0A203, 32'h0020A423, 32'h40309093, 32'h00000073,
    32'h0000000F, 32'h022081B3, 32'h0020D1B3, 32'h00309093
  };

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;

    pin = model(32'h123452B7, 32'h0);
    chk("pin_lui_imm", pin.imm, 32'h12345000);
    chk("pin_lui_sel_a", pin.sel_a, 32'd2);
    pin = model(32'h010000EF, 32'h0);
    chk("pin_jal_imm", pin.imm, 32'd16);
    chk("pin_jal_rd_we", pin.rd_we, 32'd1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ctrl", 32'(bus.out_ctrl), 32'd0);
    chk("rst_imm", bus.out_imm, 32'd0);
    @(posedge clk); #1;

    send(32'h002081B3, 32'h100);
    @(negedge clk);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_ctrl", 32'(bus.out_ctrl), 32'd2);
    chk("add_sel_a", 32'(bus.out_sel_a), 32'd0);
    chk("add_sel_b", 32'(bus.out_sel_b), 32'd0);
    chk("add_rs1", 32'(bus.out_rs1), 32'd1);
    chk("add_rs2", 32'(bus.out_rs2), 32'd2);
    chk("add_rd", 32'(bus.out_rd), 32'd3);
    chk("add_rd_we", 32'(bus.out_rd_we), 32'd1);

    send(32'h40435293, 32'h104);
    @(negedge clk);
    chk("srai_ctrl", 32'(bus.out_ctrl), 32'd13);
    chk("srai_sel_b", 32'(bus.out_sel_b), 32'd1);
    chk("srai_imm", bus.out_imm, 32'h4);
    chk("srai_rd", 32'(bus.out_rd), 32'd5);
    chk("srai_illegal", 32'(bus.out_illegal), 32'd0);

    send(32'hFE20ECE3, 32'h108);
    @(negedge clk);
    chk("bltu_ctrl", 32'(bus.out_ctrl), 32'd7);
    chk("bltu_imm", bus.out_imm, 32'hFFFFFFF8);
    chk("bltu_is_branch", 32'(bus.out_is_branch), 32'd1);
    chk("bltu_rd_we", 32'(bus.out_rd_we), 32'd0);
    chk("bltu_sel_b", 32'(bus.out_sel_b), 32'd0);
    @(posedge clk); #1;

    // Backpressure: A in main, B in skid, C held until execute drains.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'hA00);
    send(32'h40435293, 32'hB00);
    fork
      send(32'hFE20ECE3, 32'hC00);
      begin
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_a", bus.out_pc, 32'hA00);
        @(negedge clk);
        chk("bp_hold_a2", bus.out_pc, 32'hA00);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_order_b", bus.out_pc, 32'hB00);
        @(negedge clk);
        chk("bp_order_c", bus.out_pc, 32'hC00);
      end
    join
    @(negedge clk);
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Flush with main and skid full plus a same-cycle offer.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'hD00);
    send(32'h00208033, 32'hE00);
    bus.in_valid = 1'b1; bus.in_inst = 32'h40435293; bus.in_pc = 32'hF00;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_stays_empty", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // Flush with only main full, while the same-cycle offer would be accepted.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'h1100);
    bus.in_valid = 1'b1; bus.in_inst = 32'h00208033; bus.in_pc = 32'h1200;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    send(32'h00002063, 32'h300);
    @(negedge clk);
    chk("bad_br_illegal", 32'(bus.out_illegal), 32'd1);
    chk("bad_br_ctrl", 32'(bus.out_ctrl), 32'd15);
    chk("bad_br_rd_we", 32'(bus.out_rd_we), 32'd0);
    chk("bad_br_is_branch", 32'(bus.out_is_branch), 32'd0);
    send(32'h00208033, 32'h304);
    @(negedge clk);
    chk("rd0_rd_we", 32'(bus.out_rd_we), 32'd0);
    chk("rd0_ctrl", 32'(bus.out_ctrl), 32'd2);
    @(posedge clk); #1;

    for (int k = 0; k < 14; k++) begin
      bus.out_ready = (k % 3 != 2);
      send(tbl[k], 32'h2000 + 32'(4 * k));
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of traffic drops held entries and zeroes payload.
    bus.out_ready = 1'b0;
    send(32'h002081B3, 32'h4000);
    send(32'h40435293, 32'h4004);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_pc", bus.out_pc, 32'd0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
